// File: rtl/fifo_if.sv
// Producer/consumer bundle for the single-clock FIFO: push side, pop side and status.
// The FIFO drives popData/full/empty; the user side drives push/pop/pushData.
// No clock or reset in here; those stay plain ports on the FIFO itself.
interface fifo_if #(
  parameter int bitWidth = 32
);
  logic                push;
  logic                pop;
  logic [bitWidth-1:0] pushData;
  logic [bitWidth-1:0] popData;
  logic                full;
  logic                empty;

  // User side: requests data movement and watches the status flags.
  modport master (
    output push, pop, pushData,
    input  popData, full, empty
  );

  // FIFO side: accepts requests and publishes head word plus flags.
  modport slave (
    input  push, pop, pushData,
    output popData, full, empty
  );
endinterface

// File: rtl/fifo.sv
// Synchronous single-clock FIFO, any depth >= 2, show-ahead head word on popData.
// Latency: a pushed word is visible on popData the cycle after its push edge; pop has 0 read latency.
// Backpressure: full drops push unless a pop is accepted in the same cycle; pop on empty is ignored.
// Optional sticky overflow/underflow outputs when FIFO_ERR_FLAGS_EN is defined.
module fifo #(
  parameter int nrOfEntries = 16,
  parameter int bitWidth    = 32
) (
  input  logic   clock,
  input  logic   reset,
  fifo_if.slave  bus
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic   overflow,
  output logic   underflow
`endif
);

  localparam int PtrW = $clog2(nrOfEntries);
  localparam int CntW = $clog2(nrOfEntries + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(nrOfEntries - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(nrOfEntries);

  logic [bitWidth-1:0] mem_q [nrOfEntries];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q,  count_d;

  logic full_w;
  logic empty_w;
  logic wr_en;
  logic rd_en;

  // Flags decode straight off the registered count, so they never glitch.
  assign full_w  = (count_q == FullCnt);
  assign empty_w = (count_q == '0);

  // A write into a full FIFO is still legal when the head is leaving this cycle.
  assign rd_en = bus.pop  && !empty_w;
  assign wr_en = bus.push && (!full_w || rd_en);

  assign bus.full    = full_w;
  assign bus.empty   = empty_w;
  // Head word is gated to zero while empty so stale storage never leaks out.
  assign bus.popData = empty_w ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap explicitly so any depth works.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state with synchronous reset that overrides any request in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left uncleared by reset; empty gating hides old contents.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= bus.pushData;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: a dropped push or a pop with nothing stored.
  always_comb begin
    overflow_d  = overflow_q  || (bus.push && full_w && !bus.pop);
    underflow_d = underflow_q || (bus.pop && empty_w);
  end

  // Only reset clears the error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: constant vector table, directed sequences and random traffic.
// A queue-based model tracks contents from the accept rules; DUT outputs sampled 1ns after posedge.
// Flag checks are compiled in only when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo;
  localparam int DEPTH = 16;
  localparam int W     = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
`endif

  fifo_if #(.bitWidth(W)) bus ();

  fifo #(.nrOfEntries(DEPTH), .bitWidth(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clock = ~clock;

  int errs   = 0;
  int checks = 0;

  // Reference model: plain queue of stored words plus sticky error bits.
  logic [W-1:0] mq[$];
  bit ovf_m = 1'b0;
  bit unf_m = 1'b0;

  typedef struct {
    logic         rst;
    logic         push;
    logic         pop;
    logic [W-1:0] dat;
    logic         e_empty;
    logic         e_full;
    logic [W-1:0] e_pd;
    logic         e_unf;
    logic         e_ovf;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, step the model by the accept rules, then compare all outputs.
  task automatic cycle(input logic r, input logic p, input logic q, input logic [W-1:0] d);
    int  n;
    bit  wr, rd;
    reset        = r;
    bus.push     = p;
    bus.pop      = q;
    bus.pushData = d;
    @(posedge clock);
    if (r) begin
      mq.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      n  = mq.size();
      rd = q && (n > 0);
      wr = p && ((n < DEPTH) || rd);
      if (p && n == DEPTH && !q) ovf_m = 1'b1;
      if (q && n == 0)           unf_m = 1'b1;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(d);
    end
    #1;
    chk("m_empty",   W'(bus.empty), W'(mq.size() == 0));
    chk("m_full",    W'(bus.full),  W'(mq.size() == DEPTH));
    chk("m_popData", bus.popData,   (mq.size() > 0) ? mq[0] : '0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("m_overflow",  W'(overflow),  W'(ovf_m));
    chk("m_underflow", W'(underflow), W'(unf_m));
`endif
  endtask

  initial begin
    logic [W-1:0] seen;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.pushData = '0;

    // Constant vectors: reset, pop/push on empty, simultaneous ops, reset overriding push.
    //            rst  push pop  dat     empty full pd      unf  ovf
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h7,  1'b0, 1'b0, 32'h7, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h8,  1'b0, 1'b0, 32'h7, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 32'h8, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h9,  1'b0, 1'b0, 32'h9, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 32'hA,  1'b0, 1'b0, 32'hA, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 32'hB,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].dat);
      chk($sformatf("tbl%0d_empty", i), W'(bus.empty), W'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_full", i),  W'(bus.full),  W'(tbl[i].e_full));
      chk($sformatf("tbl%0d_popData", i), bus.popData, tbl[i].e_pd);
`ifdef FIFO_ERR_FLAGS_EN
      chk($sformatf("tbl%0d_underflow", i), W'(underflow), W'(tbl[i].e_unf));
      chk($sformatf("tbl%0d_overflow", i),  W'(overflow),  W'(tbl[i].e_ovf));
`endif
    end

    // Reset held two cycles, then idle two cycles.
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);

    // Overfill with 0..31: only 0..15 kept.
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 1'b0, W'(i));
    chk("fill_full",    W'(bus.full),  W'(1));
    chk("fill_popData", bus.popData,   W'(0));
`ifdef FIFO_ERR_FLAGS_EN
    chk("fill_overflow", W'(overflow), W'(1));
`endif

    // Drain with 32 pops: heads must step 0..15, then stay empty.
    for (int i = 0; i < 32; i++) begin
      if (i < DEPTH) chk($sformatf("drain_head%0d", i), bus.popData, W'(i));
      cycle(1'b0, 1'b0, 1'b1, '0);
    end
    chk("drain_empty", W'(bus.empty), W'(1));
`ifdef FIFO_ERR_FLAGS_EN
    chk("drain_underflow", W'(underflow), W'(1));
`endif

    // Full FIFO, push+pop together: stays full, 0xA5 comes out last after the wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, W'(100 + i));
    cycle(1'b0, 1'b1, 1'b1, 32'hA5);
    chk("fullpp_full", W'(bus.full), W'(1));
    for (int i = 0; i < DEPTH; i++) begin
      seen = bus.popData;
      cycle(1'b0, 1'b0, 1'b1, '0);
    end
    chk("fullpp_last", seen, 32'hA5);

    // Write 10 / read 10 / write 12 / read 12 across the pointer wrap.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, W'(200 + i));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, W'(300 + i));
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("wrap_head%0d", i), bus.popData, W'(300 + i));
      cycle(1'b0, 1'b0, 1'b1, '0);
    end

    // Mid-sequence reset discards content; flags clear.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, W'(400 + i));
    cycle(1'b1, 1'b1, 1'b1, 32'h55);
    chk("midrst_empty", W'(bus.empty), W'(1));
`ifdef FIFO_ERR_FLAGS_EN
    chk("midrst_overflow",  W'(overflow),  W'(0));
    chk("midrst_underflow", W'(underflow), W'(0));
`endif

    // Random traffic against the queue model, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 45), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
